// File: rtl/i2c_xfer_seq.sv
// Transaction sequencer in front of i2c_ctrl: takes one address/length command,
// streams write bytes in or read bytes out, and reports NAK/timeout status with done.
module i2c_xfer_seq #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err_addr_nak,
  output logic             err_data_nak,
  output logic             err_timeout,
  output logic [LEN_W-1:0] xfer_count,
  output logic             ctrl_feed,
  output logic [7:0]       ctrl_addr,
  output logic [7:0]       ctrl_tx_data,
  output logic             ctrl_rx_ack,
  input  logic             ctrl_busy,
  input  logic             ctrl_idle,
  input  logic             ctrl_tx_ack,
  input  logic [7:0]       ctrl_rx_data
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_BUSY, S_ADDR_DONE, S_SETUP,
    S_BYTE_BUSY, S_BYTE_DONE, S_STOP, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       addr_q;
  logic [LEN_W-1:0] remaining;
  logic [TMR_W-1:0] timer;
  logic             tmo_hit;
  logic             is_rd;

  assign is_rd = addr_q[0];

  // States that wait on the controller and are therefore bounded by the timer.
  function automatic logic is_timed(input state_t s);
    return s inside {S_START, S_ADDR_BUSY, S_ADDR_DONE, S_BYTE_BUSY, S_BYTE_DONE, S_STOP};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      S_IDLE:      if (cmd_valid) state_nx = S_START;
      S_START:     if (!ctrl_busy) state_nx = S_ADDR_BUSY;
      S_ADDR_BUSY: if (ctrl_busy) state_nx = S_ADDR_DONE;
      S_ADDR_DONE: if (!ctrl_busy)
                     state_nx = (ctrl_tx_ack || remaining == '0) ? S_STOP : S_SETUP;
      S_SETUP:     if (is_rd || wr_valid) state_nx = S_BYTE_BUSY;
      S_BYTE_BUSY: if (ctrl_busy) state_nx = S_BYTE_DONE;
      S_BYTE_DONE: if (!ctrl_busy)
                     state_nx = ((!is_rd && ctrl_tx_ack) || remaining == LEN_W'(1)) ? S_STOP : S_SETUP;
      S_STOP:      if (ctrl_idle) state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
    // A normal exit in the same cycle wins over the timeout.
    if (state_nx == state && is_timed(state) && timer == TMR_W'(TIMEOUT - 1)) begin
      tmo_hit  = 1'b1;
      state_nx = (state == S_STOP) ? S_DONE : S_STOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer <= '0;
    else if (state_nx != state) timer <= '0;
    else if (is_timed(state))   timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready    <= 1'b1;
      wr_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= 8'h00;
      done         <= 1'b0;
      err_addr_nak <= 1'b0;
      err_data_nak <= 1'b0;
      err_timeout  <= 1'b0;
      xfer_count   <= '0;
      ctrl_feed    <= 1'b1;
      ctrl_addr    <= 8'hFF;
      ctrl_tx_data <= 8'hFF;
      ctrl_rx_ack  <= 1'b1;
      addr_q       <= 8'h00;
      remaining    <= '0;
    end else begin
      cmd_ready <= (state_nx == S_IDLE);
      ctrl_feed <= (state_nx inside {S_IDLE, S_STOP, S_DONE});
      done      <= (state_nx == S_DONE);
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      if (tmo_hit) err_timeout <= 1'b1;
      if (state_nx == S_STOP) ctrl_rx_ack <= 1'b1;
      case (state)
        S_IDLE: if (cmd_valid) begin
          addr_q       <= cmd_addr;
          remaining    <= cmd_len;
          err_addr_nak <= 1'b0;
          err_data_nak <= 1'b0;
          err_timeout  <= 1'b0;
          xfer_count   <= '0;
        end
        S_START:     if (!ctrl_busy) ctrl_addr <= addr_q;
        S_ADDR_DONE: if (!ctrl_busy && ctrl_tx_ack) err_addr_nak <= 1'b1;
        S_SETUP: begin
          if (is_rd) begin
            ctrl_tx_data <= 8'hFF;
            ctrl_rx_ack  <= (remaining == LEN_W'(1));
          end else if (wr_valid) begin
            ctrl_tx_data <= wr_data;
            wr_ready     <= 1'b1;
          end
        end
        S_BYTE_DONE: if (!ctrl_busy) begin
          if (!is_rd && ctrl_tx_ack) begin
            err_data_nak <= 1'b1;
          end else begin
            xfer_count <= xfer_count + 1'b1;
            remaining  <= remaining - 1'b1;
            if (is_rd) begin
              rd_data  <= ctrl_rx_data;
              rd_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Scoreboard bench for i2c_xfer_seq with a behavioural i2c_ctrl model and host stream.
module tb_i2c_xfer_seq;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid, wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             done, err_addr_nak, err_data_nak, err_timeout;
  logic [LEN_W-1:0] xfer_count;
  logic             ctrl_feed, ctrl_rx_ack;
  logic [7:0]       ctrl_addr, ctrl_tx_data;
  logic             ctrl_busy, ctrl_idle, ctrl_tx_ack;
  logic [7:0]       ctrl_rx_data;

  i2c_xfer_seq #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err_addr_nak(err_addr_nak), .err_data_nak(err_data_nak),
    .err_timeout(err_timeout), .xfer_count(xfer_count),
    .ctrl_feed(ctrl_feed), .ctrl_addr(ctrl_addr), .ctrl_tx_data(ctrl_tx_data),
    .ctrl_rx_ack(ctrl_rx_ack), .ctrl_busy(ctrl_busy), .ctrl_idle(ctrl_idle),
    .ctrl_tx_ack(ctrl_tx_ack), .ctrl_rx_data(ctrl_rx_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       an;
    logic       dn;
    logic       to;
    logic [7:0] cnt;
  } done_t;

  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         wr_pulses = 0;
  int         nak_at = -1;
  bit         vip_hang = 0;
  logic [7:0] exp_bus[$];
  logic [7:0] exp_rd[$];
  bit         exp_rxack[$];
  done_t      exp_done[$];
  logic [7:0] host_q[$];
  logic [7:0] vip_rd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Host write-byte source: present the head of host_q, drop it on wr_ready.
  initial begin
    logic [7:0] tmp;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_ready && host_q.size() > 0) tmp = host_q.pop_front();
      if (host_q.size() > 0) begin
        wr_valid = 1'b1;
        wr_data  = host_q[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  // i2c_ctrl model: after feed=0 and a short gap, run one byte (busy for 4 cycles).
  initial begin
    int gap, bcnt, bidx;
    bit vrd;
    gap = 0; bcnt = 0; bidx = 0; vrd = 0;
    ctrl_busy = 1'b0; ctrl_idle = 1'b1; ctrl_tx_ack = 1'b0; ctrl_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        ctrl_busy = 1'b0; ctrl_idle = 1'b1; gap = 0; bidx = 0;
      end else if (ctrl_busy) begin
        if (!vip_hang) begin
          if (bcnt > 0) bcnt--;
          else begin
            ctrl_busy   = 1'b0;
            gap         = 0;
            ctrl_tx_ack = (bidx - 1 == nak_at);
            if (vrd && bidx > 1) begin
              if (exp_rxack.size() == 0) chk("rx_ack_unexp", 1, 0);
              else chk("rx_ack", ctrl_rx_ack, exp_rxack.pop_front());
              if (vip_rd.size() > 0) ctrl_rx_data = vip_rd.pop_front();
            end
          end
        end
      end else if (!ctrl_feed) begin
        ctrl_idle = 1'b0;
        if (gap < 4) gap++;
        else begin
          gap = 0; ctrl_busy = 1'b1; bcnt = 3;
          if (bidx == 0) begin
            vrd = ctrl_addr[0];
            if (exp_bus.size() == 0) chk("bus_unexp", 1, 0);
            else chk("bus_addr", ctrl_addr, exp_bus.pop_front());
          end else if (!vrd) begin
            if (exp_bus.size() == 0) chk("bus_unexp", 1, 0);
            else chk("bus_wdata", ctrl_tx_data, exp_bus.pop_front());
          end
          bidx++;
        end
      end else if (!ctrl_idle) begin
        if (gap < 4) gap++;
        else begin ctrl_idle = 1'b1; gap = 0; bidx = 0; end
      end else begin
        gap = 0; bidx = 0;
      end
    end
  end

  // Output monitor: read strobes and done pulses are popped against the scoreboard.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (wr_ready) wr_pulses++;
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexp", 1, 0);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("feed_at_done", ctrl_feed, 1);
        if (exp_done.size() == 0) chk("done_unexp", 1, 0);
        else begin
          e = exp_done.pop_front();
          chk("err_addr_nak", err_addr_nak, e.an);
          chk("err_data_nak", err_data_nak, e.dn);
          chk("err_timeout", err_timeout, e.to);
          chk("xfer_count", xfer_count, e.cnt);
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] a, input int len);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = LEN_W'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_taken", cmd_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    int c0 = done_cnt;
    while (done_cnt == c0 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("done_seen", done_cnt != c0, 1);
  endtask

  task automatic run_xfer(input logic [7:0] a, input int len,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input int nak, input logic ea, input logic ed,
                          input int ecnt, input int ewr);
    logic [7:0] d[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    nak_at = nak;
    host_q.delete(); vip_rd.delete();
    wr_pulses = 0;
    exp_bus.push_back(a);
    for (int i = 0; i < len; i++) begin
      if (a[0]) begin
        vip_rd.push_back(d[i]);
        exp_rd.push_back(d[i]);
        exp_rxack.push_back(i == len - 1);
      end else begin
        host_q.push_back(d[i]);
        if (nak != 0 && (nak < 0 || i + 1 <= nak)) exp_bus.push_back(d[i]);
      end
    end
    exp_done.push_back({ea, ed, 1'b0, 8'(ecnt)});
    send_cmd(a, len);
    wait_done();
    chk("wr_pulses", wr_pulses, ewr);
    @(negedge clk);
    chk("done_pulse_len", done, 0);
    chk("hold_addr_nak", err_addr_nak, ea);
    chk("hold_data_nak", err_data_nak, ed);
    chk("hold_count", xfer_count, 8'(ecnt));
    chk("bus_left", exp_bus.size(), 0);
    chk("rd_left", exp_rd.size() + exp_rxack.size(), 0);
  endtask

  initial begin
    int n, c0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_feed", ctrl_feed, 1);
    chk("rst_ctrl_addr", ctrl_addr, 8'hFF);
    chk("rst_tx_data", ctrl_tx_data, 8'hFF);
    chk("rst_rx_ack", ctrl_rx_ack, 1);
    chk("rst_pulses", {done, wr_ready, rd_valid}, 0);
    chk("rst_errs", {err_addr_nak, err_data_nak, err_timeout}, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_count", xfer_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(8'h30, 3, 8'h12, 8'h32, 8'h99, -1, 1'b0, 1'b0, 3, 3);
    run_xfer(8'h33, 3, 8'h12, 8'h32, 8'h99, -1, 1'b0, 1'b0, 3, 0);
    run_xfer(8'h34, 2, 8'hAA, 8'hBB, 8'h00,  0, 1'b1, 1'b0, 0, 0);
    run_xfer(8'h30, 3, 8'h12, 8'h32, 8'h99,  2, 1'b0, 1'b1, 1, 2);
    run_xfer(8'h31, 3, 8'h00, 8'hFF, 8'hAC, -1, 1'b0, 1'b0, 3, 0);
    run_xfer(8'h30, 0, 8'h00, 8'h00, 8'h00, -1, 1'b0, 1'b0, 0, 0);

    // Reset while the first data byte of a write is in flight.
    nak_at = -1;
    host_q.delete();
    host_q.push_back(8'h12); host_q.push_back(8'h32); host_q.push_back(8'h99);
    exp_bus.push_back(8'h30);
    send_cmd(8'h30, 3);
    n = 0;
    while (!wr_ready && n < 200) begin @(negedge clk); n++; end
    chk("mid_wr_ready", wr_ready, 1);
    c0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_feed", ctrl_feed, 1);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_ctrl_addr", ctrl_addr, 8'hFF);
    chk("mid_rst_tx_data", ctrl_tx_data, 8'hFF);
    chk("mid_rst_rx_ack", ctrl_rx_ack, 1);
    chk("mid_rst_pulses", {done, wr_ready, rd_valid}, 0);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    chk("mid_rst_count", xfer_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    host_q.delete(); exp_bus.delete();
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt, c0);
    run_xfer(8'h30, 1, 8'hAC, 8'h00, 8'h00, -1, 1'b0, 1'b0, 1, 1);

    // Controller stuck busy: ADDR_DONE times out, then STOP times out to DONE.
    vip_hang = 1'b1;
    nak_at = -1;
    host_q.delete();
    host_q.push_back(8'h55);
    exp_bus.push_back(8'h30);
    exp_done.push_back({1'b0, 1'b0, 1'b1, 8'd0});
    send_cmd(8'h30, 1);
    n = 0;
    do begin @(posedge clk); n++; end while (!ctrl_busy && n < 200);
    n = 0;
    while (!err_timeout && n < 300) begin @(negedge clk); n++; end
    // One edge into ADDR_DONE, then TIMEOUT cycles of waiting.
    chk("tmo_latency", n, TIMEOUT + 1);
    chk("tmo_feed", ctrl_feed, 1);
    wait_done();
    chk("tmo_bus_left", exp_bus.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
